// File: rtl/jt12_op_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_op_seq_if
//  Description : Slot-enable, configuration-write and per-slot operator
//                control bundle for the FM operator slot sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt12_op_seq_if;
  // Slot advance enable and configuration write port
  logic       clk_en;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_alg;
  logic [2:0] cfg_fb;

  // Per-slot operator controls
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic [2:0] fb_II;
  logic       op_fb_enable;
  logic [2:0] op_mod_src;
  logic       op_carrier;
  logic       zero;
  logic       sample_ready;

  // Stimulus / configuration side
  modport master (
    output clk_en, cfg_we, cfg_ch, cfg_alg, cfg_fb,
    input  cur_ch, cur_op, fb_II, op_fb_enable, op_mod_src,
           op_carrier, zero, sample_ready
  );

  // Sequencer side
  modport slave (
    input  clk_en, cfg_we, cfg_ch, cfg_alg, cfg_fb,
    output cur_ch, cur_op, fb_II, op_fb_enable, op_mod_src,
           op_carrier, zero, sample_ready
  );
endinterface
`default_nettype wire

// File: rtl/jt12_op_seq.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_op_seq
//  Description : Operator slot sequencer. Walks 4*NUM_CH slots per sample
//                (all M1 slots, then C1, M2, C2) and drives channel/operator
//                indices, feedback level, modulation sources and carrier flag
//                from double-buffered per-channel algorithm/feedback registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt12_op_seq #(
  parameter int NUM_CH = 6
) (
  input  logic         clk,
  input  logic         rst,
  jt12_op_seq_if.slave bus
);

  localparam int                c_SLOTS     = 4 * NUM_CH;
  localparam int                c_SLOT_W    = $clog2(c_SLOTS);
  localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(c_SLOTS - 1);
  localparam logic [2:0]        c_LAST_CH   = 3'(NUM_CH - 1);

  // Slot position: a flat counter for wrap/zero detection plus separate
  // channel and operator counters so no divider is needed.
  logic [c_SLOT_W-1:0] r_slot;
  logic [2:0]          r_cur_ch;
  logic [1:0]          r_cur_op;

  // Double-buffered per-channel configuration
  logic [2:0] r_pend_alg [NUM_CH];
  logic [2:0] r_pend_fb  [NUM_CH];
  logic [2:0] r_act_alg  [NUM_CH];
  logic [2:0] r_act_fb   [NUM_CH];

  // Registered slot outputs
  logic [2:0] r_fb_II;
  logic       r_fb_en;
  logic [2:0] r_mod_src;
  logic       r_carrier;
  logic       r_zero;
  logic       r_sample_ready;

  // Next-state wires
  logic                w_wrap;
  logic [c_SLOT_W-1:0] w_slot_next;
  logic [2:0]          w_ch_next;
  logic [1:0]          w_op_next;
  logic [2:0]          w_pend_alg [NUM_CH];
  logic [2:0]          w_pend_fb  [NUM_CH];
  logic [2:0]          w_act_alg  [NUM_CH];
  logic [2:0]          w_act_fb   [NUM_CH];
  logic [2:0]          w_sel_alg;
  logic [2:0]          w_sel_fb;
  logic [3:0]          w_dec;

  // Algorithm decode: returns {carrier, src[2:0]} for one operator.
  // Sources are bit0=M1, bit1=C1, bit2=M2; every source slot group precedes
  // its destination group, so values are always ready when consumed.
  function automatic logic [3:0] f_decode(input logic [2:0] alg,
                                          input logic [1:0] op);
    logic [3:0] d;
    d = 4'b0000;
    case ({alg, op})
      // alg0: M1 -> C1 -> M2 -> C2
      5'b000_01: d = 4'b0_001;
      5'b000_10: d = 4'b0_010;
      5'b000_11: d = 4'b1_100;
      // alg1: (M1|C1) -> M2 -> C2
      5'b001_10: d = 4'b0_011;
      5'b001_11: d = 4'b1_100;
      // alg2: C1 -> M2, (M1|M2) -> C2
      5'b010_10: d = 4'b0_010;
      5'b010_11: d = 4'b1_101;
      // alg3: M1 -> C1, (C1|M2) -> C2
      5'b011_01: d = 4'b0_001;
      5'b011_11: d = 4'b1_110;
      // alg4: two stacks M1->C1, M2->C2
      5'b100_01: d = 4'b1_001;
      5'b100_11: d = 4'b1_100;
      // alg5: M1 drives C1, M2, C2
      5'b101_01: d = 4'b1_001;
      5'b101_10: d = 4'b1_001;
      5'b101_11: d = 4'b1_001;
      // alg6: M1 -> C1, M2 and C2 unmodulated
      5'b110_01: d = 4'b1_001;
      5'b110_10: d = 4'b1_000;
      5'b110_11: d = 4'b1_000;
      // alg7: four unmodulated carriers
      5'b111_00: d = 4'b1_000;
      5'b111_01: d = 4'b1_000;
      5'b111_10: d = 4'b1_000;
      5'b111_11: d = 4'b1_000;
      default:   d = 4'b0_000;
    endcase
    return d;
  endfunction

  // Next slot position, buffered config with same-cycle write forwarding,
  // and decode of the slot that is about to be presented.
  always_comb begin
    w_wrap      = bus.clk_en && (r_slot == c_LAST_SLOT);
    w_slot_next = w_wrap ? '0 : r_slot + 1'b1;
    w_ch_next   = (r_cur_ch == c_LAST_CH) ? 3'd0 : r_cur_ch + 3'd1;
    w_op_next   = (r_cur_ch == c_LAST_CH) ? r_cur_op + 2'd1 : r_cur_op;
    w_sel_alg   = 3'd0;
    w_sel_fb    = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pend_alg[i] = r_pend_alg[i];
      w_pend_fb[i]  = r_pend_fb[i];
      if (bus.cfg_we && (bus.cfg_ch == 3'(i))) begin
        w_pend_alg[i] = bus.cfg_alg;
        w_pend_fb[i]  = bus.cfg_fb;
      end
      w_act_alg[i] = w_wrap ? w_pend_alg[i] : r_act_alg[i];
      w_act_fb[i]  = w_wrap ? w_pend_fb[i]  : r_act_fb[i];
      if (w_ch_next == 3'(i)) begin
        w_sel_alg = w_act_alg[i];
        w_sel_fb  = w_act_fb[i];
      end
    end
    w_dec = f_decode(w_sel_alg, w_op_next);
  end

  // Sequencing state, configuration buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot         <= '0;
      r_cur_ch       <= 3'd0;
      r_cur_op       <= 2'd0;
      r_fb_II        <= 3'd0;
      r_fb_en        <= 1'b1;
      r_mod_src      <= 3'd0;
      r_carrier      <= 1'b0;
      r_zero         <= 1'b1;
      r_sample_ready <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pend_alg[i] <= 3'd0;
        r_pend_fb[i]  <= 3'd0;
        r_act_alg[i]  <= 3'd0;
        r_act_fb[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pend_alg[i] <= w_pend_alg[i];
        r_pend_fb[i]  <= w_pend_fb[i];
      end
      if (bus.clk_en) begin
        r_slot         <= w_slot_next;
        r_cur_ch       <= w_ch_next;
        r_cur_op       <= w_op_next;
        r_fb_II        <= w_sel_fb;
        r_fb_en        <= (w_op_next == 2'd0);
        r_mod_src      <= w_dec[2:0];
        r_carrier      <= w_dec[3];
        r_zero         <= (w_slot_next == '0);
        r_sample_ready <= w_wrap;
        for (int i = 0; i < NUM_CH; i++) begin
          r_act_alg[i] <= w_act_alg[i];
          r_act_fb[i]  <= w_act_fb[i];
        end
      end else begin
        r_sample_ready <= 1'b0;
      end
    end
  end

  assign bus.cur_ch       = r_cur_ch;
  assign bus.cur_op       = r_cur_op;
  assign bus.fb_II        = r_fb_II;
  assign bus.op_fb_enable = r_fb_en;
  assign bus.op_mod_src   = r_mod_src;
  assign bus.op_carrier   = r_carrier;
  assign bus.zero         = r_zero;
  assign bus.sample_ready = r_sample_ready;

endmodule
`default_nettype wire

// File: tb/tb_jt12_op_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt12_op_seq
//  Description : Directed self-checking bench for jt12_op_seq with a
//                reference model feeding an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_op_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jt12_op_seq_if bus ();

  jt12_op_seq #(.NUM_CH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference decode tables: sources per operator (bit0=M1,bit1=C1,bit2=M2)
  // and carrier mask per algorithm (bit n = operator n).
  logic [2:0] t_src [0:7][0:3] = '{
    '{3'd0, 3'd1, 3'd2, 3'd4},
    '{3'd0, 3'd0, 3'd3, 3'd4},
    '{3'd0, 3'd0, 3'd2, 3'd5},
    '{3'd0, 3'd1, 3'd0, 3'd6},
    '{3'd0, 3'd1, 3'd0, 3'd4},
    '{3'd0, 3'd1, 3'd1, 3'd1},
    '{3'd0, 3'd1, 3'd0, 3'd0},
    '{3'd0, 3'd0, 3'd0, 3'd0}
  };
  logic [3:0] t_car [0:7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                              4'b1010, 4'b1110, 4'b1110, 4'b1111};

  // Model state
  int         m_slot;
  logic       m_sr;
  logic [2:0] m_pend_alg [0:5];
  logic [2:0] m_pend_fb  [0:5];
  logic [2:0] m_act_alg  [0:5];
  logic [2:0] m_act_fb   [0:5];

  logic [14:0] exp_q [$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  function automatic logic [14:0] f_expect();
    int ch;
    int op;
    logic [2:0] a;
    ch = m_slot % 6;
    op = m_slot / 6;
    a  = m_act_alg[ch];
    return {3'(ch), 2'(op), m_act_fb[ch], (op == 0),
            t_src[a][op], t_car[a][op], (m_slot == 0), m_sr};
  endfunction

  // Drive one clock of stimulus, advance the model, queue the expectation,
  // then check the DUT after the edge.
  task automatic step(input logic r, input logic en, input logic we,
                      input logic [2:0] ch, input logic [2:0] alg,
                      input logic [2:0] fb);
    logic [14:0] obs;
    logic [14:0] expv;
    logic        wrap;
    rst         = r;
    bus.clk_en  = en;
    bus.cfg_we  = we;
    bus.cfg_ch  = ch;
    bus.cfg_alg = alg;
    bus.cfg_fb  = fb;
    if (r) begin
      m_slot = 0;
      m_sr   = 1'b0;
      for (int i = 0; i < 6; i++) begin
        m_pend_alg[i] = 3'd0; m_pend_fb[i] = 3'd0;
        m_act_alg[i]  = 3'd0; m_act_fb[i]  = 3'd0;
      end
    end else begin
      if (we && ch < 3'd6) begin
        m_pend_alg[ch] = alg;
        m_pend_fb[ch]  = fb;
      end
      if (en) begin
        wrap = (m_slot == 23);
        if (wrap)
          for (int i = 0; i < 6; i++) begin
            m_act_alg[i] = m_pend_alg[i];
            m_act_fb[i]  = m_pend_fb[i];
          end
        m_slot = wrap ? 0 : m_slot + 1;
        m_sr   = wrap;
      end else begin
        m_sr = 1'b0;
      end
    end
    exp_q.push_back(f_expect());
    @(posedge clk);
    #1;
    n_step++;
    obs = {bus.cur_ch, bus.cur_op, bus.fb_II, bus.op_fb_enable,
           bus.op_mod_src, bus.op_carrier, bus.zero, bus.sample_ready};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL step%0d: observed %h, expected queue empty", n_step, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        n_fail++;
        $error("FAIL step%0d slot%0d: observed %h expected %h",
               n_step, m_slot, obs, expv);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  // Advance until the current slot equals s (bounded to one sample)
  task automatic goto_slot(input int s);
    for (int i = 0; i < 24 && m_slot != s; i++) run(1);
  endtask

  initial begin
    bus.clk_en = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_ch = 3'd0; bus.cfg_alg = 3'd0; bus.cfg_fb = 3'd0;
    m_slot = 0; m_sr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_pend_alg[i] = 3'd0; m_pend_fb[i] = 3'd0;
      m_act_alg[i]  = 3'd0; m_act_fb[i]  = 3'd0;
    end

    // Reset state, including reset winning over write and enable
    step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 3'd7, 3'd7);

    // Slot order over two samples
    run(48);

    // Write buffering: ch2 alg4 fb5 at slot 10
    goto_slot(10);
    step(1'b0, 1'b1, 1'b1, 3'd2, 3'd4, 3'd5);
    run(40);

    // Coincident write on the wrap cycle
    goto_slot(23);
    step(1'b0, 1'b1, 1'b1, 3'd0, 3'd7, 3'd1);
    run(24);

    // Algorithm sweep on ch0
    for (int a = 0; a < 8; a++) begin
      goto_slot(3);
      step(1'b0, 1'b1, 1'b1, 3'd0, 3'(a), 3'(7 - a));
      goto_slot(0);
      run(24);
    end

    // Invalid channel write has no effect
    step(1'b0, 1'b1, 1'b1, 3'd6, 3'd7, 3'd7);
    step(1'b0, 1'b1, 1'b1, 3'd7, 3'd5, 3'd3);
    run(48);

    // Enable gating at slot 7 with a write during the freeze
    goto_slot(7);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd3, 3'd5, 3'd3);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    goto_slot(0);
    run(24);

    // Freeze across the last slot: no wrap, no pulse
    goto_slot(23);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    run(3);

    // Mid-sample reset with a pending write to ch1
    goto_slot(17);
    step(1'b0, 1'b1, 1'b1, 3'd1, 3'd6, 3'd2);
    step(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    run(48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
